// File: rtl/psx_dev_responder_if.sv
// PSX controller-port bus: host drives psx_clk/cmd/att, device returns dat/ack.
interface psx_dev_responder_if;
   logic psx_clk;
   logic cmd;
   logic att;
   logic dat;
   logic ack;

   modport master (output psx_clk, cmd, att, input dat, ack);
   modport slave  (input psx_clk, cmd, att, output dat, ack);
endinterface

// File: rtl/psx_dev_responder.sv
// PSX digital-pad responder: 5-byte frame, ID 0x41/0x5A, button bytes latched at att fall.
// Optional command checking (byte0==0x01, byte1==0x42) enabled by defining PSX_CMD_CHECK_EN.
module psx_dev_responder #(
   parameter int ACK_DELAY = 20,
   parameter int ACK_WIDTH = 4
)(
   input  logic                clk,
   input  logic                rst,
   psx_dev_responder_if.slave  bus,
   input  logic [15:0]         buttons,
   output logic [7:0]          rx_byte,
   output logic                rx_valid,
   output logic                frame_done,
   output logic                frame_err
);
   typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, LAST, IGNORE} state_t;

   localparam logic [7:0] DLY_LAST = 8'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
   localparam logic [7:0] WID_LAST = 8'((ACK_WIDTH > 0) ? ACK_WIDTH - 1 : 0);

   state_t      state, state_n;
   logic [1:0]  clk_sy, cmd_sy, att_sy;
   logic        clk_q, att_q;
   logic [15:0] btn_lat, btn_n;
   logic [2:0]  byte_idx, idx_n, bit_cnt, bit_n;
   logic [7:0]  rx_sh, rx_sh_n, rx_new, tx_byte, tx_n, cnt, cnt_n, rxb_n;
   logic        dat_r, dat_n, ack_r, ack_n, rxv_n, fd_n, fe_n, cmd_bad;

   wire psx_rise = clk_sy[1] & ~clk_q;
   wire psx_fall = ~clk_sy[1] & clk_q;
   wire att_rise = att_sy[1] & ~att_q;
   wire att_fall = ~att_sy[1] & att_q;

   assign bus.dat = dat_r;
   assign bus.ack = ack_r;
   assign rx_new  = {cmd_sy[1], rx_sh[7:1]};

`ifdef PSX_CMD_CHECK_EN
   assign cmd_bad = ((byte_idx == 3'd0) && (rx_new != 8'h01)) ||
                    ((byte_idx == 3'd1) && (rx_new != 8'h42));
`else
   assign cmd_bad = 1'b0;
`endif

   function automatic logic [7:0] tx_for(input logic [2:0] idx, input logic [15:0] btn);
      case (idx)
         3'd0:    tx_for = 8'hFF;
         3'd1:    tx_for = 8'h41;
         3'd2:    tx_for = 8'h5A;
         3'd3:    tx_for = btn[7:0];
         3'd4:    tx_for = btn[15:8];
         default: tx_for = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clk_sy     <= 2'b11;
         cmd_sy     <= 2'b11;
         att_sy     <= 2'b11;
         clk_q      <= 1'b1;
         att_q      <= 1'b1;
         btn_lat    <= 16'hFFFF;
         byte_idx   <= '0;
         bit_cnt    <= '0;
         rx_sh      <= '0;
         tx_byte    <= 8'hFF;
         cnt        <= '0;
         dat_r      <= 1'b1;
         ack_r      <= 1'b1;
         rx_byte    <= '0;
         rx_valid   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         clk_sy     <= {clk_sy[0], bus.psx_clk};
         cmd_sy     <= {cmd_sy[0], bus.cmd};
         att_sy     <= {att_sy[0], bus.att};
         clk_q      <= clk_sy[1];
         att_q      <= att_sy[1];
         btn_lat    <= btn_n;
         byte_idx   <= idx_n;
         bit_cnt    <= bit_n;
         rx_sh      <= rx_sh_n;
         tx_byte    <= tx_n;
         cnt        <= cnt_n;
         dat_r      <= dat_n;
         ack_r      <= ack_n;
         rx_byte    <= rxb_n;
         rx_valid   <= rxv_n;
         frame_done <= fd_n;
         frame_err  <= fe_n;
      end
   end

   always_comb begin
      state_n = state;
      btn_n   = btn_lat;
      idx_n   = byte_idx;
      bit_n   = bit_cnt;
      rx_sh_n = rx_sh;
      tx_n    = tx_byte;
      cnt_n   = cnt;
      dat_n   = dat_r;
      ack_n   = ack_r;
      rxb_n   = rx_byte;
      rxv_n   = 1'b0;
      fd_n    = 1'b0;
      fe_n    = 1'b0;
      case (state)
         IDLE: begin
            dat_n = 1'b1;
            ack_n = 1'b1;
            if (att_fall) begin
               btn_n   = buttons;
               idx_n   = '0;
               bit_n   = '0;
               tx_n    = 8'hFF;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            // bit_cnt counts rising edges seen, so it indexes the bit still owed to the host
            if (psx_fall) dat_n = tx_byte[bit_cnt];
            if (psx_rise) begin
               rx_sh_n = rx_new;
               bit_n   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rxb_n = rx_new;
                  rxv_n = 1'b1;
                  cnt_n = '0;
                  if (byte_idx == 3'd4) state_n = LAST;
                  else if (cmd_bad) begin
                     state_n = IGNORE;
                     dat_n   = 1'b1;
                  end else state_n = ACK_WAIT;
               end
            end
         end
         ACK_WAIT: begin
            if (cnt >= DLY_LAST) begin
               ack_n   = 1'b0;
               cnt_n   = '0;
               state_n = ACK_PULSE;
            end else cnt_n = cnt + 8'd1;
         end
         ACK_PULSE: begin
            if (cnt >= WID_LAST) begin
               ack_n   = 1'b1;
               cnt_n   = '0;
               idx_n   = byte_idx + 3'd1;
               bit_n   = '0;
               tx_n    = tx_for(idx_n, btn_lat);
               dat_n   = tx_n[0];
               state_n = SHIFT;
            end else cnt_n = cnt + 8'd1;
         end
         LAST: begin
            ack_n = 1'b1;
            if (att_rise) begin
               fd_n    = 1'b1;
               dat_n   = 1'b1;
               state_n = IDLE;
            end
         end
         IGNORE: begin
            dat_n = 1'b1;
            ack_n = 1'b1;
            if (att_rise) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // host deselect before the frame's last byte is an aborted frame
      if (att_rise && (state == SHIFT || state == ACK_WAIT || state == ACK_PULSE)) begin
         state_n = IDLE;
         fe_n    = 1'b1;
         ack_n   = 1'b1;
         dat_n   = 1'b1;
         rxv_n   = 1'b0;
      end
   end
endmodule

// File: tb/tb_psx_dev_responder.sv
// Directed bench for psx_dev_responder: acts as PSX host, checks with immediate assertions.
module tb_psx_dev_responder;
   localparam int HP = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] buttons = 16'hFFFF;
   logic [7:0]  rx_byte;
   logic        rx_valid, frame_done, frame_err;
   int          total = 0, bad = 0;

   psx_dev_responder_if bus();

   psx_dev_responder #(.ACK_DELAY(20), .ACK_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus), .buttons(buttons),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // event monitor
   int n_rxv = 0, n_fd = 0, n_fe = 0, n_ackf = 0, n_wbad = 0, ack_run = 0;
   always @(negedge clk) begin
      if (rx_valid === 1'b1) n_rxv++;
      if (frame_done === 1'b1) n_fd++;
      if (frame_err === 1'b1) n_fe++;
      if (bus.ack === 1'b0) begin
         if (ack_run == 0) n_ackf++;
         ack_run++;
      end else if (ack_run != 0) begin
         if (ack_run != 4) n_wbad++;
         ack_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] c, output logic [7:0] d);
      for (int i = 0; i < 8; i++) begin
         bus.psx_clk = 1'b0;
         bus.cmd     = c[i];
         cyc(HP);
         d[i] = bus.dat;
         bus.psx_clk = 1'b1;
         cyc(HP);
      end
   endtask

   task automatic wait_ack(output bit ok);
      int t;
      ok = 1'b0;
      t  = 0;
      while (bus.ack !== 1'b0 && t < 200) begin cyc(1); t++; end
      if (bus.ack === 1'b0) begin
         t = 0;
         while (bus.ack !== 1'b1 && t < 50) begin cyc(1); t++; end
         ok = (bus.ack === 1'b1);
      end
   endtask

   task automatic frame(input logic [39:0] cmds, input int chg_after, input logic [15:0] btn_new,
                        output logic [39:0] dats, output int acks);
      logic [7:0] d;
      bit ok;
      acks = 0;
      dats = '0;
      bus.att = 1'b0;
      cyc(HP);
      for (int b = 0; b < 5; b++) begin
         xfer(cmds[b*8 +: 8], d);
         dats[b*8 +: 8] = d;
         if (b == chg_after) buttons = btn_new;
         if (b < 4) begin
            wait_ack(ok);
            if (ok) acks++;
         end
      end
      cyc(HP);
      bus.att = 1'b1;
      cyc(4 * HP);
   endtask

   initial begin
      logic [39:0] dats;
      logic [7:0]  d;
      int acks, b_rxv, b_fd, b_fe, b_ackf, b_wbad;
      bit ok;

      bus.psx_clk = 1'b1;
      bus.cmd     = 1'b1;
      bus.att     = 1'b1;
      cyc(5);
      rst = 1'b0;
      cyc(2);
      chk("reset_dat", 40'(bus.dat), 40'h1);
      chk("reset_ack", 40'(bus.ack), 40'h1);
      chk("reset_rx_byte", 40'(rx_byte), 40'h0);
      chk("reset_pulses", 40'({rx_valid, frame_done, frame_err}), 40'h0);

      // full frame
      b_rxv = n_rxv; b_fd = n_fd; b_fe = n_fe; b_ackf = n_ackf; b_wbad = n_wbad;
      buttons = 16'hFFFE;
      frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h01}, -1, 16'h0, dats, acks);
      chk("full_dat", dats, {8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      chk("full_acks_done", 40'(acks), 40'd4);
      chk("full_ack_pulses", 40'(n_ackf - b_ackf), 40'd4);
      chk("full_ack_width", 40'(n_wbad - b_wbad), 40'd0);
      chk("full_rx_valid", 40'(n_rxv - b_rxv), 40'd5);
      chk("full_frame_done", 40'(n_fd - b_fd), 40'd1);
      chk("full_frame_err", 40'(n_fe - b_fe), 40'd0);
      chk("full_rx_byte", 40'(rx_byte), 40'h00);

      // buttons changed mid-frame must not reach tx
      b_fd = n_fd;
      buttons = 16'hFFFE;
      frame({8'h3C, 8'hA5, 8'h00, 8'h42, 8'h01}, 2, 16'h0000, dats, acks);
      chk("midchg_dat", dats, {8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      chk("midchg_rx_byte", 40'(rx_byte), 40'h3C);
      chk("midchg_frame_done", 40'(n_fd - b_fd), 40'd1);

      // abort after byte 2
      b_fe = n_fe; b_fd = n_fd;
      buttons = 16'h1234;
      bus.att = 1'b0;
      cyc(HP);
      xfer(8'h01, d); wait_ack(ok);
      xfer(8'h42, d); wait_ack(ok);
      xfer(8'h00, d);
      chk("abort_byte2_dat", 40'(d), 40'h5A);
      bus.att = 1'b1;
      cyc(4 * HP);
      chk("abort_frame_err", 40'(n_fe - b_fe), 40'd1);
      chk("abort_frame_done", 40'(n_fd - b_fd), 40'd0);
      chk("abort_ack_dat", 40'({bus.ack, bus.dat}), 40'h3);
      b_fd = n_fd;
      frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h01}, -1, 16'h0, dats, acks);
      chk("after_abort_dat", dats, {8'h12, 8'h34, 8'h5A, 8'h41, 8'hFF});
      chk("after_abort_done", 40'(n_fd - b_fd), 40'd1);

      // bad first command byte
      b_fd = n_fd; b_ackf = n_ackf;
      buttons = 16'hFFFE;
`ifdef PSX_CMD_CHECK_EN
      bus.att = 1'b0;
      cyc(HP);
      xfer(8'h81, d);
      wait_ack(ok);
      chk("badcmd_no_ack", 40'(ok), 40'h0);
      xfer(8'h00, d);
      chk("badcmd_dat", 40'(d), 40'hFF);
      bus.att = 1'b1;
      cyc(4 * HP);
      chk("badcmd_ack_pulses", 40'(n_ackf - b_ackf), 40'd0);
      chk("badcmd_frame_done", 40'(n_fd - b_fd), 40'd0);
`else
      frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h81}, -1, 16'h0, dats, acks);
      chk("badcmd_dat", dats, {8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      chk("badcmd_ack_pulses", 40'(n_ackf - b_ackf), 40'd4);
      chk("badcmd_frame_done", 40'(n_fd - b_fd), 40'd1);
`endif

      // reset during ack pulse
      b_fe = n_fe; b_fd = n_fd;
      bus.att = 1'b0;
      cyc(HP);
      xfer(8'h01, d);
      begin
         int t = 0;
         while (bus.ack !== 1'b0 && t < 200) begin cyc(1); t++; end
      end
      chk("rstack_ack_low", 40'(bus.ack), 40'h0);
      rst = 1'b1;
      bus.att = 1'b1;
      cyc(1);
      chk("rstack_ack", 40'(bus.ack), 40'h1);
      chk("rstack_dat", 40'(bus.dat), 40'h1);
      chk("rstack_rx_byte", 40'(rx_byte), 40'h0);
      cyc(2);
      rst = 1'b0;
      cyc(4 * HP);
      chk("rstack_no_err", 40'(n_fe - b_fe), 40'd0);
      frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h01}, -1, 16'h0, dats, acks);
      chk("rstack_next_dat", dats, {8'hFF, 8'hFE, 8'h5A, 8'h41, 8'hFF});
      chk("rstack_next_done", 40'(n_fd - b_fd), 40'd1);

      // psx_clk activity while deselected
      b_rxv = n_rxv; b_ackf = n_ackf;
      xfer(8'h55, d);
      chk("desel_rx_valid", 40'(n_rxv - b_rxv), 40'd0);
      chk("desel_dat_seen", 40'(d), 40'hFF);
      chk("desel_ack", 40'({bus.ack, 32'(n_ackf - b_ackf)}), {8'h1, 32'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/psx_dev_responder.md
PSX_DEV_RESPONDER -- requirements
Module: psx_dev_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 20, clk cycles from last bit's rising psx_clk edge to ack assertion.
REQ-002 SHALL have parameter ACK_WIDTH, default 4, clk cycles ack is held low.
REQ-003 SHALL have ports: clk  in  1  system clock, all logic on rising edge; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: psx_clk  in  1  host bus clock, idle high; cmd  in  1  host data, LSB first; att  in  1  active-low frame select.
REQ-006 SHALL have ports: buttons  in  16  active-low button state, bit 0 = SELECT.
REQ-007 SHALL have ports: dat  out  1  device data to host; ack  out  1  active-low byte acknowledge.
REQ-008 SHALL have ports: rx_byte  out  8  last received cmd byte; rx_valid  out  1  one-cycle pulse per completed byte; frame_done  out  1  one-cycle pulse; frame_err  out  1  one-cycle pulse.

Function
REQ-009 SHALL pass psx_clk, cmd, att through 2-flop synchronizers; all edge detection on synchronized signals.
REQ-010 SHALL sample cmd into rx shift register, LSB first, on each synchronized psx_clk rising edge while selected.
REQ-011 SHALL drive dat with the next tx bit, LSB first, on each synchronized psx_clk falling edge; bit 0 driven at byte start.
REQ-012 SHALL use states IDLE, SHIFT, ACK_WAIT, ACK_PULSE, LAST, IGNORE.
REQ-013 IDLE: on att falling -> latch buttons, byte_idx=0, bit_cnt=0, load tx=0xFF, go SHIFT.
REQ-014 SHIFT: after 8th rising edge -> rx_byte updated, rx_valid pulses next cycle; byte_idx<4 -> ACK_WAIT; byte_idx==4 -> LAST.
REQ-015 Tx bytes by byte_idx: 0->0xFF, 1->0x41, 2->0x5A, 3->latched buttons[7:0], 4->latched buttons[15:8].
REQ-016 ACK_WAIT: count ACK_DELAY cycles -> ack=0, go ACK_PULSE.
REQ-017 ACK_PULSE: after ACK_WIDTH cycles -> ack=1, byte_idx+1, bit_cnt=0, load next tx byte, go SHIFT.
REQ-018 LAST: no ack; on att rising -> frame_done pulse, go IDLE.
REQ-019 IGNORE: dat=1, ack=1, no rx_valid; on att rising -> IDLE, no frame_done, no frame_err.
REQ-020 att rising in SHIFT, ACK_WAIT or ACK_PULSE -> frame_err pulse, ack=1, dat=1, go IDLE same cycle.
REQ-021 psx_clk edges while att high SHALL be ignored; psx_clk edges during ACK_WAIT/ACK_PULSE SHALL be ignored.
REQ-022 Counters SHALL be wide enough for ACK_DELAY, ACK_WIDTH up to 255 without wrap.
REQ-023 Buttons SHALL be latched only at att falling; changes mid-frame SHALL not affect tx.

Reset
REQ-024 rst SHALL force state IDLE, dat=1, ack=1, rx_byte=0x00, rx_valid=0, frame_done=0, frame_err=0, counters 0, synchronizers to 1.
REQ-025 rst mid-frame SHALL abort without frame_err; next att falling starts a new frame.

Configuration
REQ-026 Macro PSX_CMD_CHECK_EN defined: byte 0 != 0x01 or byte 1 != 0x42 -> go IGNORE after that byte instead of ACK_WAIT.
REQ-027 PSX_CMD_CHECK_EN undefined: received bytes SHALL not affect flow; IGNORE unreachable.

Verification
REQ-028 Full frame, cmd 0x01,0x42,0x00,0x00,0x00, buttons=0xFFFE -> dat 0xFF,0x41,0x5A,0xFE,0xFF; 4 ack pulses of 4 cycles; 5 rx_valid; frame_done once.
REQ-029 att raised after byte 2 -> frame_err one pulse, ack/dat high, next frame completes normally.
REQ-030 PSX_CMD_CHECK_EN, byte 0 = 0x81 -> no ack, dat stays 1, no frame_done; undefined -> full frame as REQ-028.
REQ-031 buttons changed 0xFFFE->0x0000 mid-frame -> bytes 3,4 still 0xFE,0xFF.
REQ-032 rst asserted during ACK_PULSE -> ack=1 next cycle, all outputs at reset values, no frame_err.
REQ-033 psx_clk toggled 8 times with att high -> no rx_valid, dat=1, ack=1.
